// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: PC-unit FSM states and default datapath width.
package cpu_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic {PC_RUN, PC_SLEEP} pc_state_e;

  // Index width for an n-entry select, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wake_pri_enc.sv
// Lowest-index-wins priority encoder over the wake event vector.
module wake_pri_enc #(
  parameter int N    = 4,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
)(
  input  logic [N-1:0]    req,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  // Scan high to low so the lowest set index is the final assignment.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = ID_W'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/pc_unit.sv
// IF-stage program counter: trap/redirect/sequential next-PC select plus a
// WFI sleep FSM with edge-detected maskable wake sources and a sleep counter.
module pc_unit
  import cpu_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              INC       = 4,
  parameter int              NUM_WAKE  = 4,
  parameter int              CNT_W     = 16,
  localparam int             ID_W      = (NUM_WAKE > 1) ? $clog2(NUM_WAKE) : 1
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_i,
  input  logic                wait_i,
  input  logic                redirect_vld_i,
  input  logic [XLEN-1:0]     redirect_pc_i,
  input  logic                trap_vld_i,
  input  logic [XLEN-1:0]     trap_pc_i,
  input  logic                wfi_i,
  input  logic [NUM_WAKE-1:0] wake_i,
  input  logic [NUM_WAKE-1:0] wake_en_i,
  output logic [XLEN-1:0]     pc_o,
  output logic                sleep_o,
  output logic                wake_vld_o,
  output logic [ID_W-1:0]     wake_id_o,
  output logic [CNT_W-1:0]    sleep_cnt_o
);

  pc_state_e           state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d, pc_inc;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wvld_q, wvld_d;
  logic [ID_W-1:0]     wid_q, wid_d;
  logic [NUM_WAKE-1:0] wake_q, ev;
  logic [ID_W-1:0]     ev_idx;
  logic                ev_any;

  // Rising edges only, so a line held high across WFI never wakes the core.
  assign ev = wake_i & ~wake_q & wake_en_i;

  wake_pri_enc #(.N(NUM_WAKE), .ID_W(ID_W)) u_enc (
    .req (ev),
    .idx (ev_idx),
    .any (ev_any)
  );

  assign pc_inc = pc_q + XLEN'(INC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PC_RUN;
      pc_q    <= RESET_VEC;
      cnt_q   <= '0;
      wvld_q  <= 1'b0;
      wid_q   <= '0;
      wake_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      wvld_q  <= wvld_d;
      wid_q   <= wid_d;
      wake_q  <= wake_i;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    wvld_d  = 1'b0;
    wid_d   = wid_q;
    case (state_q)
      PC_RUN: begin
        if (trap_vld_i) begin
          pc_d = trap_pc_i;
        end else if (stall_i || wait_i) begin
          pc_d = pc_q;
        end else if (redirect_vld_i) begin
          pc_d = redirect_pc_i;
        end else if (wfi_i) begin
          state_d = PC_SLEEP;
          cnt_d   = '0;
        end else begin
          pc_d = pc_inc;
        end
      end
      PC_SLEEP: begin
        // Trap exit is silent: the wake report is for wake sources only.
        if (trap_vld_i) begin
          pc_d    = trap_pc_i;
          state_d = PC_RUN;
        end else if (ev_any) begin
          pc_d    = pc_inc;
          state_d = PC_RUN;
          wvld_d  = 1'b1;
          wid_d   = ev_idx;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = PC_RUN;
    endcase
  end

  assign pc_o        = pc_q;
  assign sleep_o     = (state_q == PC_SLEEP);
  assign wake_vld_o  = wvld_q;
  assign wake_id_o   = wid_q;
  assign sleep_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: vector table, directed corner sequences,
// and a randomized run against a cycle-level behavioural model.
module tb_pc_unit;

  localparam int          XLEN  = 32;
  localparam int          NW    = 4;
  localparam int          CNT_W = 4;
  localparam logic [31:0] RV    = 32'h100;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            stall_r = 0, wait_r = 0, redir_r = 0, trap_r = 0, wfi_r = 0;
  logic [XLEN-1:0] rpc_r = '0, tpc_r = '0;
  logic [NW-1:0]   wake_r = '0, en_r = '0;
  logic [XLEN-1:0] pc_o;
  logic            sleep_o, wake_vld_o;
  logic [1:0]      wake_id_o;
  logic [CNT_W-1:0] sleep_cnt_o;

  int n_chk = 0, n_fail = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  bit          m_sleep, m_vld;
  int          m_id, m_cnt;
  logic [NW-1:0] m_prev;

  pc_unit #(.XLEN(XLEN), .RESET_VEC(RV), .INC(4), .NUM_WAKE(NW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_r), .wait_i(wait_r),
    .redirect_vld_i(redir_r), .redirect_pc_i(rpc_r),
    .trap_vld_i(trap_r), .trap_pc_i(tpc_r), .wfi_i(wfi_r),
    .wake_i(wake_r), .wake_en_i(en_r),
    .pc_o(pc_o), .sleep_o(sleep_o), .wake_vld_o(wake_vld_o),
    .wake_id_o(wake_id_o), .sleep_cnt_o(sleep_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of the architectural behaviour, evaluated on the inputs in force.
  task automatic model_tick();
    logic [NW-1:0] ev;
    if (rst) begin
      m_pc = RV; m_sleep = 0; m_vld = 0; m_id = 0; m_cnt = 0; m_prev = '0;
      return;
    end
    ev    = wake_r & ~m_prev & en_r;
    m_vld = 0;
    if (!m_sleep) begin
      if (trap_r)                m_pc = tpc_r;
      else if (stall_r || wait_r) ;
      else if (redir_r)          m_pc = rpc_r;
      else if (wfi_r)            begin m_sleep = 1; m_cnt = 0; end
      else                       m_pc = m_pc + 32'd4;
    end else begin
      if (trap_r) begin
        m_pc = tpc_r; m_sleep = 0;
      end else if (ev != 0) begin
        m_pc = m_pc + 32'd4; m_sleep = 0; m_vld = 1;
        for (int i = 0; i < NW; i++) if (ev[i]) begin m_id = i; break; end
      end else if (m_cnt < (1 << CNT_W) - 1) begin
        m_cnt++;
      end
    end
    m_prev = wake_r;
  endtask

  task automatic chk_model();
    chk("pc_vs_model",    pc_o,        m_pc);
    chk("sleep_vs_model", sleep_o,     m_sleep);
    chk("vld_vs_model",   wake_vld_o,  m_vld);
    chk("id_vs_model",    wake_id_o,   m_id);
    chk("cnt_vs_model",   sleep_cnt_o, m_cnt);
  endtask

  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
    chk_model();
  endtask

  task automatic idle();
    stall_r = 0; wait_r = 0; redir_r = 0; trap_r = 0; wfi_r = 0;
  endtask

  task automatic jump(input logic [31:0] target);
    idle(); redir_r = 1; rpc_r = target; step(); idle();
  endtask

  typedef struct {
    logic        stall, wt, redir;
    logic [31:0] rpc;
    logic        trap;
    logic [31:0] tpc;
    logic        wfi;
    logic [31:0] exp_pc;
    logic        exp_sleep;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h104, 0};
    vecs[1] = '{0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h108, 0};
    vecs[2] = '{0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h10C, 0};
    vecs[3] = '{1, 0, 1, 32'h400, 0, 32'h0,  0, 32'h10C, 0};
    vecs[4] = '{0, 1, 1, 32'h400, 0, 32'h0,  1, 32'h10C, 0};
    vecs[5] = '{0, 0, 1, 32'h400, 0, 32'h0,  0, 32'h400, 0};
    vecs[6] = '{1, 1, 1, 32'h500, 1, 32'h80, 1, 32'h080, 0};
    vecs[7] = '{0, 0, 1, 32'h1F0, 0, 32'h0,  1, 32'h1F0, 0};
    vecs[8] = '{0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h1F4, 0};

    // Reset held three cycles
    rst = 1;
    for (int i = 0; i < 3; i++) step();
    chk("reset_pc",    pc_o,        32'h100);
    chk("reset_sleep", sleep_o,     1'b0);
    chk("reset_vld",   wake_vld_o,  1'b0);
    chk("reset_id",    wake_id_o,   2'd0);
    chk("reset_cnt",   sleep_cnt_o, 4'd0);
    rst = 0;

    for (int i = 0; i < 9; i++) begin
      stall_r = vecs[i].stall; wait_r = vecs[i].wt; redir_r = vecs[i].redir;
      rpc_r = vecs[i].rpc; trap_r = vecs[i].trap; tpc_r = vecs[i].tpc; wfi_r = vecs[i].wfi;
      step();
      chk($sformatf("vec%0d_pc", i),    pc_o,    vecs[i].exp_pc);
      chk($sformatf("vec%0d_sleep", i), sleep_o, vecs[i].exp_sleep);
    end
    idle();

    // Stall masks a redirect; release lets it through
    jump(32'h200);
    stall_r = 1; redir_r = 1; rpc_r = 32'h400; step();
    chk("stall_hold_pc", pc_o, 32'h200);
    stall_r = 0; step();
    chk("stall_release_pc", pc_o, 32'h400);
    idle();

    // WFI, 10 sleeping cycles, wake on source 2
    jump(32'h300);
    wfi_r = 1; step(); wfi_r = 0;
    chk("wfi_sleep", sleep_o, 1'b1);
    chk("wfi_pc",    pc_o,    32'h300);
    for (int i = 0; i < 10; i++) step();
    en_r = 4'b0100; wake_r = 4'b0100; step();
    chk("wake_pc",    pc_o,        32'h304);
    chk("wake_vld",   wake_vld_o,  1'b1);
    chk("wake_id",    wake_id_o,   2'd2);
    chk("wake_cnt",   sleep_cnt_o, 4'd10);
    chk("wake_sleep", sleep_o,     1'b0);
    step();
    chk("wake_pulse_end", wake_vld_o,  1'b0);
    chk("wake_id_hold",   wake_id_o,   2'd2);
    chk("cnt_hold",       sleep_cnt_o, 4'd10);

    // Masked edge and pre-held line do not wake; trap exits silently
    wake_r = 4'b1000; en_r = 4'b1010; step();
    jump(32'h600);
    wfi_r = 1; step(); wfi_r = 0;
    wake_r = 4'b1010; en_r = 4'b1000; step();
    step();
    chk("masked_still_sleep", sleep_o, 1'b1);
    chk("masked_pc",          pc_o,    32'h600);
    trap_r = 1; tpc_r = 32'h80; step(); trap_r = 0;
    chk("trap_wake_pc",    pc_o,       32'h80);
    chk("trap_wake_sleep", sleep_o,    1'b0);
    chk("trap_wake_vld",   wake_vld_o, 1'b0);
    wake_r = '0; en_r = '0; step();

    // PC wraparound, and trap overriding a stall in RUN
    jump(32'hFFFF_FFFC);
    step();
    chk("wrap_pc", pc_o, 32'h0);
    stall_r = 1; trap_r = 1; tpc_r = 32'hABC0; step(); idle();
    chk("trap_over_stall", pc_o, 32'hABC0);

    // Counter saturation, then reset mid-sleep
    wfi_r = 1; step(); wfi_r = 0;
    for (int i = 0; i < 20; i++) step();
    chk("cnt_saturate", sleep_cnt_o, 4'd15);
    chk("sat_sleep",    sleep_o,     1'b1);
    wake_r = 4'b0001; en_r = 4'b0001; rst = 1; step(); rst = 0;
    chk("rst_sleep_pc",    pc_o,        32'h100);
    chk("rst_sleep_sleep", sleep_o,     1'b0);
    chk("rst_sleep_vld",   wake_vld_o,  1'b0);
    chk("rst_sleep_id",    wake_id_o,   2'd0);
    chk("rst_sleep_cnt",   sleep_cnt_o, 4'd0);
    wake_r = '0; en_r = '0;

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(299) == 0);
      trap_r  = ($urandom_range(31) == 0);
      tpc_r   = $urandom;
      stall_r = ($urandom_range(7) == 0);
      wait_r  = ($urandom_range(7) == 0);
      redir_r = ($urandom_range(7) == 0);
      rpc_r   = $urandom;
      wfi_r   = ($urandom_range(5) == 0);
      for (int b = 0; b < NW; b++) if ($urandom_range(7) == 0) wake_r[b] = ~wake_r[b];
      if ((c % 16) == 0) en_r = NW'($urandom);
      step();
    end
    rst = 0; idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
